// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared constants and FSM state type for the wide add sequencer
package adder_seq_pkg;

  // Width of the single time-shared adder slice.
  localparam int SLICE_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/sq_root_carry_adder.sv
// rtl/sq_root_carry_adder.sv - 5-bit square-root carry-select adder slice
// Ports: a, b (5b) + c_in -> sum (5b), c_out. Purely combinational.
module sq_root_carry_adder (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       c_in,
  output logic [4:0] sum,
  output logic       c_out
);

  // Groups of 2 and 3 bits: the upper group is precomputed for both carry
  // values so only a mux sits after the low group's carry.
  logic [2:0] lo;
  logic [3:0] hi_c0;
  logic [3:0] hi_c1;

  always_comb begin
    lo    = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, c_in};
    hi_c0 = {1'b0, a[4:2]} + {1'b0, b[4:2]};
    hi_c1 = {1'b0, a[4:2]} + {1'b0, b[4:2]} + 4'd1;
  end

  assign sum[1:0] = lo[1:0];
  assign sum[4:2] = lo[2] ? hi_c1[2:0] : hi_c0[2:0];
  assign c_out    = lo[2] ? hi_c1[3]   : hi_c0[3];

endmodule

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - wide adder built by sequencing one 5-bit slice LSB first
// Ports: clk, rst (sync, active-high); start/a/b/c_in accepted when ready;
// busy while slicing; done pulses one cycle with sum/c_out valid and held.
module wide_add_sequencer #(
  parameter int SLICE_W  = 5,
  parameter int N_SLICES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [SLICE_W*N_SLICES-1:0]   a,
  input  logic [SLICE_W*N_SLICES-1:0]   b,
  input  logic                          c_in,
  output logic                          ready,
  output logic                          busy,
  output logic [SLICE_W*N_SLICES-1:0]   sum,
  output logic                          c_out,
  output logic                          done
);

  import adder_seq_pkg::*;

  localparam int W     = SLICE_W * N_SLICES;
  localparam int IDX_W = $clog2(N_SLICES);

  state_t             state;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               last_slice;

  // Slice select from the latched operands only, so nothing from the
  // input pins reaches the adder or the outputs combinationally.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < N_SLICES; i++) begin
      if (idx == IDX_W'(i)) begin
        slice_a = a_reg[i*SLICE_W +: SLICE_W];
        slice_b = b_reg[i*SLICE_W +: SLICE_W];
      end
    end
  end

  assign last_slice = (idx == IDX_W'(N_SLICES - 1));

  sq_root_carry_adder u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  // ready/busy/done are registered copies of the state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= c_in;
            idx   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < N_SLICES; i++) begin
            if (idx == IDX_W'(i)) begin
              sum[i*SLICE_W +: SLICE_W] <= slice_sum;
            end
          end
          carry <= slice_cout;
          idx   <= idx + 1'b1;
          if (last_slice) begin
            c_out <= slice_cout;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - directed self-checking bench for wide_add_sequencer
module tb_wide_add_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] a;
  logic [19:0] b;
  logic        c_in;
  logic        ready;
  logic        busy;
  logic [19:0] sum;
  logic        c_out;
  logic        done;

  int n_vec  = 0;
  int n_miss = 0;

  wide_add_sequencer #(.SLICE_W(5), .N_SLICES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .ready (ready),
    .busy  (busy),
    .sum   (sum),
    .c_out (c_out),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [19:0] exp_sum, input logic exp_cout);
    check({tag, ".ready"}, 32'(ready), 32'd1);
    check({tag, ".busy"},  32'(busy),  32'd0);
    check({tag, ".done"},  32'(done),  32'd0);
    check({tag, ".sum"},   32'(sum),   32'(exp_sum));
    check({tag, ".cout"},  32'(c_out), 32'(exp_cout));
  endtask

  // One-cycle start, then wait (bounded) for done; latency must be 5 edges.
  task automatic run_op(input string tag, input logic [19:0] va, input logic [19:0] vb,
                        input logic vc, input logic [19:0] exp_sum, input logic exp_cout);
    int cycles;
    a = va; b = vb; c_in = vc; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va; b = ~vb; c_in = ~vc;
    cycles = 1;
    while (!done && cycles < 20) begin
      check({tag, ".busy"}, 32'(busy), 32'd1);
      tick();
      cycles++;
    end
    check({tag, ".latency"}, 32'(cycles), 32'd5);
    check({tag, ".done"},    32'(done),   32'd1);
    check({tag, ".sum"},     32'(sum),    32'(exp_sum));
    check({tag, ".cout"},    32'(c_out),  32'(exp_cout));
    tick();
    check_idle({tag, ".after"}, exp_sum, exp_cout);
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    #1;

    // Reset held for two cycles, then released.
    for (int i = 0; i < 2; i++) begin
      tick();
      check_idle("rst_hold", 20'h00000, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_idle("rst_rel", 20'h00000, 1'b0);
    end

    // Reset and start together: reset wins.
    rst = 1'b1; start = 1'b1; a = 20'h12345; b = 20'h11111;
    tick();
    rst = 1'b0; start = 1'b0;
    check_idle("rst_start", 20'h00000, 1'b0);
    tick();
    check_idle("rst_start2", 20'h00000, 1'b0);

    run_op("basic",  20'h00005, 20'h00017, 1'b0, 20'h0001C, 1'b0);
    run_op("ripple", 20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1);
    run_op("s0s1",   20'h0001F, 20'h00001, 1'b0, 20'h00020, 1'b0);
    run_op("mixed",  20'hABCDE, 20'h54321, 1'b0, 20'hFFFFF, 1'b0);
    run_op("wrap",   20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1);
    run_op("cin",    20'h003FF, 20'h00000, 1'b1, 20'h00400, 1'b0);

    // Start held high, operands changing every cycle during RUN.
    a = 20'h00001; b = 20'h00002; c_in = 1'b0; start = 1'b1;
    tick();
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) n_done++;
      check("hold.busy", 32'(busy), 32'd1);
      a = 20'(32'h11111 * (i + 2)); b = 20'(32'h02020 * (i + 3)); c_in = 1'(i);
      tick();
    end
    check("hold.done", 32'(done), 32'd1);
    check("hold.sum",  32'(sum),  32'h00003);
    check("hold.cout", 32'(c_out), 32'd0);
    a = 20'hFFFFF; b = 20'hFFFFF;
    tick();
    check("hold.ready", 32'(ready), 32'd1);
    check("hold.ndone", 32'(n_done + 32'(done)), 32'd0);
    a = 20'h00100; b = 20'h00200; c_in = 1'b1;
    tick();
    start = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
    check("hold2.busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("hold2.done", 32'(done), 32'd1);
    check("hold2.sum",  32'(sum),  32'h00301);
    tick();

    // Reset in the middle of RUN with idx = 2.
    a = 20'h01234; b = 20'h04321; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("abort", 20'h00000, 1'b0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) n_done++;
    end
    check("abort.nodone", 32'(n_done), 32'd0);
    check_idle("abort.idle", 20'h00000, 1'b0);
    run_op("after_abort", 20'h01234, 20'h04321, 1'b0, 20'h05555, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
